// File: rtl/char_ram_arbiter.sv
// Single-port arbiter for the text-mode character RAM.
// Renderer has priority; a pending CPU access wins after MAX_WAIT denials.
module char_ram_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_we,
   input  logic              cpu_re,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rdata_valid,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_rdata,
   output logic              vga_rdata_valid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   logic              pend_valid;
   logic              pend_we;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_wdata;
   logic [3:0]        wait_cnt;
   logic              cpu_ret;
   logic              vga_ret;

   logic              src_valid;
   logic              src_we;
   logic [ADDR_W-1:0] src_addr;
   logic [DATA_W-1:0] src_wdata;
   logic              grant_cpu;
   logic              grant_vga;

   // A held request (pending slot) masks any new CPU pulse; write beats read.
   always_comb begin
      src_valid = pend_valid | cpu_we | cpu_re;
      src_we    = pend_valid ? pend_we    : cpu_we;
      src_addr  = pend_valid ? pend_addr  : cpu_addr;
      src_wdata = pend_valid ? pend_wdata : cpu_wdata;
   end

   always_comb begin
      grant_cpu = reset & src_valid & (~vga_req | (wait_cnt == MAX_W));
      grant_vga = reset & vga_req & ~grant_cpu;
   end

   always_comb begin
      ram_en    = grant_cpu | grant_vga;
      ram_we    = grant_cpu & src_we;
      ram_addr  = grant_cpu ? src_addr : vga_addr;
      ram_wdata = grant_cpu ? src_wdata : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_valid <= 1'b0;
         pend_we    <= 1'b0;
         pend_addr  <= '0;
         pend_wdata <= '0;
         wait_cnt   <= '0;
      end else if (grant_cpu) begin
         pend_valid <= 1'b0;
         wait_cnt   <= '0;
      end else if (src_valid) begin
         if (!pend_valid) begin
            pend_valid <= 1'b1;
            pend_we    <= cpu_we;
            pend_addr  <= cpu_addr;
            pend_wdata <= cpu_wdata;
            wait_cnt   <= 4'd1;
         end else if (wait_cnt != MAX_W) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

   // Read returns: RAM data lands one cycle after the grant.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cpu_ret         <= 1'b0;
         vga_ret         <= 1'b0;
         cpu_rdata       <= '0;
         cpu_rdata_valid <= 1'b0;
      end else begin
         cpu_ret         <= grant_cpu & ~src_we;
         vga_ret         <= grant_vga;
         cpu_rdata_valid <= cpu_ret;
         if (cpu_ret) cpu_rdata <= ram_rdata;
      end
   end

   assign cpu_stall       = pend_valid;
   assign vga_rdata       = ram_rdata;
   assign vga_rdata_valid = vga_ret;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Scoreboard bench for char_ram_arbiter with a behavioural RAM.
// Expected RAM writes and CPU read returns are queued with their cycle.
module tb_char_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_we = 1'b0;
   logic        cpu_re = 1'b0;
   logic [11:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_stall;
   logic [7:0]  cpu_rdata;
   logic        cpu_rdata_valid;
   logic        vga_req = 1'b0;
   logic [11:0] vga_addr = '0;
   logic [7:0]  vga_rdata;
   logic        vga_rdata_valid;
   logic        ram_en;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = '0;

   char_ram_arbiter #(.ADDR_W(12), .DATA_W(8), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
      .cpu_rdata_valid(cpu_rdata_valid),
      .vga_req(vga_req), .vga_addr(vga_addr),
      .vga_rdata(vga_rdata), .vga_rdata_valid(vga_rdata_valid),
      .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [4096];

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   typedef struct {
      int         cyc;
      logic [11:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t wq[$];
   exp_t rq[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: every RAM write and every CPU read return must match the queue.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (ram_en && ram_we) begin
         n_chk++;
         if (wq.size() == 0) begin
            n_fail++;
            $display("FAIL ram_write @cyc %0d: got addr %h data %h, required none",
                     cyc, ram_addr, ram_wdata);
         end else begin
            e = wq.pop_front();
            if (e.cyc != cyc || e.addr != ram_addr || e.data != ram_wdata) begin
               n_fail++;
               $display("FAIL ram_write: got cyc %0d addr %h data %h, required cyc %0d addr %h data %h",
                        cyc, ram_addr, ram_wdata, e.cyc, e.addr, e.data);
            end
         end
      end
      if (cpu_rdata_valid) begin
         n_chk++;
         if (rq.size() == 0) begin
            n_fail++;
            $display("FAIL cpu_read @cyc %0d: got data %h, required no valid",
                     cyc, cpu_rdata);
         end else begin
            e = rq.pop_front();
            if (e.cyc != cyc || e.data != cpu_rdata) begin
               n_fail++;
               $display("FAIL cpu_read addr %h: got cyc %0d data %h, required cyc %0d data %h",
                        e.addr, cyc, cpu_rdata, e.cyc, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'hFFF] = 8'h7E;

      // reset state
      repeat (3) tick();
      @(negedge clk);
      chk("rst_stall", 32'(cpu_stall), 0);
      chk("rst_rdata", 32'(cpu_rdata), 0);
      chk("rst_rvalid", 32'(cpu_rdata_valid), 0);
      chk("rst_vvalid", 32'(vga_rdata_valid), 0);
      chk("rst_ram_en", 32'(ram_en), 0);
      tick();
      reset = 1'b1;
      repeat (2) tick();

      // idle renderer: write then read back
      t0 = cyc;
      cpu_we = 1; cpu_addr = 12'h010; cpu_wdata = 8'h41;
      wq.push_back('{t0, 12'h010, 8'h41});
      @(negedge clk);
      chk("idle_stall0", 32'(cpu_stall), 0);
      tick();
      cpu_we = 0; cpu_re = 1;
      rq.push_back('{t0 + 3, 12'h010, 8'h41});
      @(negedge clk);
      chk("idle_stall1", 32'(cpu_stall), 0);
      tick();
      cpu_re = 0;
      @(negedge clk);
      chk("idle_stall2", 32'(cpu_stall), 0);
      repeat (4) tick();

      // continuous renderer, write waits MAX_WAIT cycles
      vga_req = 1; vga_addr = 12'h100;
      tick();
      tick();
      t0 = cyc;
      cpu_we = 1; cpu_addr = 12'h123; cpu_wdata = 8'h99;
      wq.push_back('{t0 + 4, 12'h123, 8'h99});
      for (int k = 0; k < 7; k++) begin
         if (k > 0) begin
            tick();
            cpu_we = 0;
         end
         @(negedge clk);
         chk($sformatf("cont_stall_c%0d", k), 32'(cpu_stall),
             32'((k >= 1 && k <= 4) ? 1 : 0));
         chk($sformatf("cont_vvalid_c%0d", k), 32'(vga_rdata_valid),
             32'((k == 5) ? 0 : 1));
      end
      repeat (2) tick();

      // read under contention
      t0 = cyc;
      cpu_re = 1; cpu_addr = 12'hFFF;
      rq.push_back('{t0 + 6, 12'hFFF, 8'h7E});
      tick();
      cpu_re = 0;
      repeat (7) tick();
      @(negedge clk);
      chk("cont_rdata_held", 32'(cpu_rdata), 32'h7E);

      // simultaneous write and read: write wins, read dropped
      vga_req = 0;
      tick();
      tick();
      t0 = cyc;
      cpu_we = 1; cpu_re = 1; cpu_addr = 12'h020; cpu_wdata = 8'h55;
      wq.push_back('{t0, 12'h020, 8'h55});
      tick();
      cpu_we = 0; cpu_re = 0;
      repeat (4) tick();
      @(negedge clk);
      chk("both_mem", 32'(mem[12'h020]), 32'h55);

      // new request ignored while stalled
      vga_req = 1;
      tick();
      tick();
      t0 = cyc;
      cpu_we = 1; cpu_addr = 12'h2C0; cpu_wdata = 8'h5A;
      wq.push_back('{t0 + 4, 12'h2C0, 8'h5A});
      tick();
      cpu_we = 0;
      tick();
      cpu_we = 1; cpu_addr = 12'h300; cpu_wdata = 8'hEE;
      @(negedge clk);
      chk("ign_stall", 32'(cpu_stall), 1);
      tick();
      cpu_we = 0;
      repeat (6) tick();
      @(negedge clk);
      chk("ign_mem300", 32'(mem[12'h300]), 0);

      // reset during a stalled write
      tick();
      t0 = cyc;
      cpu_we = 1; cpu_addr = 12'h0AB; cpu_wdata = 8'h11;
      tick();
      cpu_we = 0;
      tick();
      reset = 0;
      @(negedge clk);
      chk("rst_mid_ram_en", 32'(ram_en), 0);
      tick();
      reset = 1;
      @(negedge clk);
      chk("rst_mid_stall", 32'(cpu_stall), 0);
      chk("rst_mid_rdata", 32'(cpu_rdata), 0);
      chk("rst_mid_rvalid", 32'(cpu_rdata_valid), 0);
      chk("rst_mid_vvalid", 32'(vga_rdata_valid), 0);
      repeat (6) tick();
      @(negedge clk);
      chk("rst_mid_mem", 32'(mem[12'h0AB]), 0);

      // reset during an in-flight read return
      vga_req = 0;
      tick();
      cpu_re = 1; cpu_addr = 12'h010;
      tick();
      cpu_re = 0; reset = 0;
      tick();
      reset = 1;
      @(negedge clk);
      chk("rst_rd_rvalid0", 32'(cpu_rdata_valid), 0);
      tick();
      @(negedge clk);
      chk("rst_rd_rvalid1", 32'(cpu_rdata_valid), 0);
      repeat (3) tick();

      chk("wq_drained", 32'(wq.size()), 0);
      chk("rq_drained", 32'(rq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
